si_tag_serializer: RTL

//  Consumes the multi-tag-per-cycle output of the tag converter: NUMBER_OF_WORDS parallel

---
 rtl/si_tag_serializer.sv | 93 +++++++++
 1 files changed

// File: rtl/si_tag_serializer.sv
// Serializes a multi-slot tag beat into one tag per cycle, in slot order.
// AXI-Stream on both sides; a beat is held until its last kept slot is loaded.
module si_tag_serializer #(
  parameter int NUMBER_OF_WORDS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [NUMBER_OF_WORDS-1:0][63:0] s_axis_tagtime,
  input  logic [NUMBER_OF_WORDS-1:0][5:0]  s_axis_channel,
  input  logic [NUMBER_OF_WORDS-1:0]       s_axis_tkeep,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [63:0]                     m_axis_tagtime,
  output logic signed [5:0]               m_axis_channel,
  output logic                            m_axis_tlast,
  output logic [63:0]                     tag_count
);

  localparam int N  = NUMBER_OF_WORDS;
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0][63:0] hold_time;
  logic [N-1:0][5:0]  hold_ch;
  logic [N-1:0]       pending;
  logic [SW-1:0]      sel;
  logic               advance;
  logic               last;
  logic               load;
  logic               accept;
  logic               capture;

  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) sel = SW'(i);
    end
  end

  // one-hot test: clearing the lowest set bit leaves nothing
  assign last    = (pending != '0) &&
                   ((pending & (pending - N'(1))) == '0);
  assign advance = !m_axis_tvalid || m_axis_tready;
  assign load    = advance && (pending != '0);

  assign s_axis_tready = !rst &&
                         ((pending == '0) || (advance && last));
  assign accept  = s_axis_tvalid && s_axis_tready;
  assign capture = accept && (s_axis_tkeep != '0);

  always_ff @(posedge clk) begin
    if (capture) begin
      hold_time <= s_axis_tagtime;
      hold_ch   <= s_axis_channel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else if (capture) begin
      pending <= s_axis_tkeep;
    end else if (load) begin
      pending[sel] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axis_tagtime <= '0;
      m_axis_channel <= '0;
    end else if (load) begin
      m_axis_tvalid  <= 1'b1;
      m_axis_tlast   <= last;
      m_axis_tagtime <= hold_time[sel];
      m_axis_channel <= hold_ch[sel];
    end else if (advance) begin
      m_axis_tvalid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_count <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      tag_count <= tag_count + 64'd1;
    end
  end

endmodule
